// File: rtl/chain_frame_fifo.sv
// chain_frame_fifo
//
// Frame-level store-and-forward buffer behind the correlator daisy-chain.
// The chain never stalls, so every word is either stored or dropped. Words
// only become visible to the AXI4-Stream master side once their frame's
// tlast word has been stored. A frame that does not fit is discarded whole.
//
// Optional feature: define CHAIN_FIFO_DROP_COUNT_EN to add drop_count_o, a
// 16-bit saturating count of discarded frames.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high
//   s_tvalid_i   : chain word valid (no ready, source never stalls)
//   s_tlast_i    : last word of a chain frame
//   s_tdata_i    : chain word [WIDTH]
//   m_tvalid_o   : output word valid (committed data available)
//   m_tready_i   : downstream ready
//   m_tlast_o    : last word of the output frame
//   m_tdata_o    : output word [WIDTH]
//   overflow_o   : one-cycle pulse per discarded frame
//   drop_count_o : (CHAIN_FIFO_DROP_COUNT_EN only) saturating drop count
//   level_o      : committed words not yet read [ABITS+1]
module chain_frame_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16,
    localparam int ABITS = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic             overflow_o,
`ifdef CHAIN_FIFO_DROP_COUNT_EN
    output logic [15:0]      drop_count_o,
`endif
    output logic [ABITS:0]   level_o
);

    typedef logic [ABITS:0] ptr_t;
    typedef enum logic {ACCEPT, DROP} state_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    // Stored word is {tlast, data}; contents are never reset.
    logic [WIDTH:0] mem [DEPTH];

    state_t state, state_nxt;
    ptr_t   wr_ptr, wr_nxt;
    ptr_t   cmt_ptr, cmt_nxt;
    ptr_t   rd_ptr;
    ptr_t   used;
    logic   full;
    logic   we;
    logic   ovf_nxt;
    logic   rd_en;

    // Full counts tentative words too, and uses the registered read pointer,
    // so a same-cycle read never rescues a write into a full buffer.
    assign used = wr_ptr - rd_ptr;
    assign full = (used == DEPTH_P);

    // ---- write side: next-state / control ----
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_ptr;
        cmt_nxt   = cmt_ptr;
        we        = 1'b0;
        ovf_nxt   = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (s_tvalid_i) begin
                    if (!full) begin
                        we     = 1'b1;
                        wr_nxt = wr_ptr + ptr_t'(1);
                        if (s_tlast_i)
                            cmt_nxt = wr_ptr + ptr_t'(1);
                    end else begin
                        // Rewind the partial frame; if this was its last
                        // word there is nothing left to skip.
                        wr_nxt  = cmt_ptr;
                        ovf_nxt = 1'b1;
                        if (!s_tlast_i)
                            state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                if (s_tvalid_i && s_tlast_i)
                    state_nxt = ACCEPT;
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // ---- write side: registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_nxt;
            cmt_ptr    <= cmt_nxt;
            overflow_o <= ovf_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[wr_ptr[ABITS-1:0]] <= {s_tlast_i, s_tdata_i};
    end

    // ---- read side ----
    assign m_tvalid_o               = (rd_ptr != cmt_ptr);
    assign rd_en                    = m_tvalid_o && m_tready_i;
    assign {m_tlast_o, m_tdata_o}   = mem[rd_ptr[ABITS-1:0]];
    assign level_o                  = cmt_ptr - rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rd_ptr <= '0;
        else if (rd_en)
            rd_ptr <= rd_ptr + ptr_t'(1);
    end

`ifdef CHAIN_FIFO_DROP_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_count_o <= '0;
        else if (overflow_o)
            drop_count_o <= sat_inc16(drop_count_o);
    end
`endif

endmodule

// File: tb/tb_chain_frame_fifo.sv
// Testbench for chain_frame_fifo (WIDTH = 7, DEPTH = 16).
// Directed frames with hand-computed expectations, plus a small frame-queue
// reference model that predicts the output stream, level and overflow.
module tb_chain_frame_fifo;

    localparam int WIDTH = 7;
    localparam int DEPTH = 16;

    logic             clock;
    logic             reset;
    logic             s_tvalid_i;
    logic             s_tlast_i;
    logic [WIDTH-1:0] s_tdata_i;
    logic             m_tvalid_o;
    logic             m_tready_i;
    logic             m_tlast_o;
    logic [WIDTH-1:0] m_tdata_o;
    logic             overflow_o;
    logic [4:0]       level_o;
`ifdef CHAIN_FIFO_DROP_COUNT_EN
    logic [15:0]      drop_count_o;
`endif

    chain_frame_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .s_tvalid_i  (s_tvalid_i),
        .s_tlast_i   (s_tlast_i),
        .s_tdata_i   (s_tdata_i),
        .m_tvalid_o  (m_tvalid_o),
        .m_tready_i  (m_tready_i),
        .m_tlast_o   (m_tlast_o),
        .m_tdata_o   (m_tdata_o),
        .overflow_o  (overflow_o),
`ifdef CHAIN_FIFO_DROP_COUNT_EN
        .drop_count_o(drop_count_o),
`endif
        .level_o     (level_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: committed words, pending (uncommitted) words, drop mode.
    logic [7:0] q[$];
    logic [7:0] pend[$];
    bit         mdrop   = 1'b0;
    bit         exp_ovf = 1'b0;

    // Observations of the DUT for the directed checks.
    int ovf_cnt, ovf_at, cur_word, valid_seen, max_level, out_cnt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        mdrop   = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model, then cross the edge and observe.
    task automatic step(input bit v, input bit l, input int d, input bit r);
        bit mfull;
        s_tvalid_i = v;
        s_tlast_i  = l;
        s_tdata_i  = WIDTH'(d);
        m_tready_i = r;
        #1;
        check_eq("tvalid", int'(m_tvalid_o), int'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("tdata", int'(m_tdata_o), int'(q[0][6:0]));
            check_eq("tlast", int'(m_tlast_o), int'(q[0][7]));
        end
        check_eq("level", int'(level_o), q.size());
        check_eq("overflow", int'(overflow_o), int'(exp_ovf));
        if (m_tvalid_o && r) out_cnt++;

        mfull   = (q.size() + pend.size()) == DEPTH;
        exp_ovf = 1'b0;
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v) begin
            if (mdrop) begin
                if (l) mdrop = 1'b0;
            end else if (!mfull) begin
                pend.push_back({l, WIDTH'(d)});
                if (l) begin
                    foreach (pend[i]) q.push_back(pend[i]);
                    pend.delete();
                end
            end else begin
                pend.delete();
                exp_ovf = 1'b1;
                if (!l) mdrop = 1'b1;
            end
        end

        @(posedge clock);
        #1;
        if (overflow_o) begin
            ovf_cnt++;
            ovf_at = cur_word;
        end
        if (m_tvalid_o) valid_seen++;
        if (int'(level_o) > max_level) max_level = int'(level_o);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, r);
    endtask

    task automatic clear_obs();
        ovf_cnt = 0; ovf_at = 0; cur_word = 0;
        valid_seen = 0; max_level = 0; out_cnt = 0;
    endtask

    int dval;

    initial begin
        reset      = 1'b1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_tdata_i  = '0;
        m_tready_i = 1'b0;
        clear_obs();
        model_reset();
        #12;
        check_eq("rst_tvalid", int'(m_tvalid_o), 0);
        check_eq("rst_level", int'(level_o), 0);
        check_eq("rst_overflow", int'(overflow_o), 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 1: basic 5-word frame, ready high
        clear_obs();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, i == 5, i, 1'b1);
            if (i == 4) check_eq("s1_tvalid_before_last", int'(m_tvalid_o), 0);
        end
        check_eq("s1_tvalid_after_last", int'(m_tvalid_o), 1);
        check_eq("s1_first_word", int'(m_tdata_o), 1);
        idle(6, 1'b1);
        check_eq("s1_out_cnt", out_cnt, 5);
        check_eq("s1_peak_level", max_level, 5);

        // 2: backpressure, two 4-word frames
        clear_obs();
        for (int i = 0; i < 8; i++) step(1'b1, (i % 4) == 3, 8'h10 + i, 1'b0);
        check_eq("s2_level", int'(level_o), 8);
        check_eq("s2_held_data", int'(m_tdata_o), 8'h10);
        check_eq("s2_held_last", int'(m_tlast_o), 0);
        idle(10, 1'b1);
        check_eq("s2_out_cnt", out_cnt, 8);
        check_eq("s2_level_empty", int'(level_o), 0);

        // 3: overflow mid-frame (12-word frame, then 10-word frame)
        clear_obs();
        for (int i = 1; i <= 12; i++) step(1'b1, i == 12, 8'h20 + i, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cur_word = i;
            step(1'b1, i == 10, 8'h40 + i, 1'b0);
        end
        check_eq("s3_ovf_cnt", ovf_cnt, 1);
        check_eq("s3_ovf_word", ovf_at, 5);
        check_eq("s3_level", int'(level_o), 12);
        idle(16, 1'b1);
        check_eq("s3_out_cnt", out_cnt, 12);
        for (int i = 1; i <= 3; i++) step(1'b1, i == 3, 8'h60 + i, 1'b1);
        idle(5, 1'b1);
        check_eq("s3_out_after", out_cnt, 15);

        // 4: oversize 20-word frame into an empty FIFO
        clear_obs();
        for (int i = 1; i <= 20; i++) begin
            cur_word = i;
            step(1'b1, i == 20, i, 1'b1);
        end
        idle(2, 1'b1);
        check_eq("s4_ovf_cnt", ovf_cnt, 1);
        check_eq("s4_ovf_word", ovf_at, 17);
        check_eq("s4_valid_seen", valid_seen, 0);
        check_eq("s4_out_none", out_cnt, 0);
        step(1'b1, 1'b0, 8'h7A, 1'b1);
        step(1'b1, 1'b1, 8'h7B, 1'b1);
        idle(4, 1'b1);
        check_eq("s4_out_cnt", out_cnt, 2);

        // 5: wrap-around, 40 back-to-back 3-word frames, random ready
        dval = 0;
        for (int f = 0; f < 40; f++) begin
            for (int w = 0; w < 3; w++) begin
                step(1'b1, w == 2, dval & 8'h7F, 1'($urandom_range(0, 1)));
                dval++;
            end
        end
        idle(20, 1'b1);
        check_eq("s5_drained", int'(level_o), 0);

        // 6: async reset mid-frame with 6 committed words pending
        clear_obs();
        for (int i = 0; i < 6; i++) step(1'b1, (i % 3) == 2, 8'h30 + i, 1'b0);
        step(1'b1, 1'b0, 8'h40, 1'b0);
        step(1'b1, 1'b0, 8'h41, 1'b0);
        check_eq("s6_level_pre", int'(level_o), 6);
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_eq("s6_rst_tvalid", int'(m_tvalid_o), 0);
        check_eq("s6_rst_level", int'(level_o), 0);
`ifdef CHAIN_FIFO_DROP_COUNT_EN
        check_eq("s6_drop_count", int'(drop_count_o), 0);
`endif
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 1; i <= 3; i++) step(1'b1, i == 3, 8'h50 + i, 1'b1);
        idle(5, 1'b1);
        check_eq("s6_out_cnt", out_cnt, 3);
        check_eq("s6_level_end", int'(level_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chain_frame_fifo.md
# chain_frame_fifo

Frame-level store-and-forward buffer sitting directly downstream of the correlator daisy-chain. The chain cannot accept backpressure, so this block absorbs its serial output stream and re-presents it as an AXI4-Stream master with `tready` flow control. Any frame that does not fit completely is discarded whole, so downstream only ever sees complete frames.

## Interface

**Parameters**
- `WIDTH`, 7: data bits per chain word.
- `DEPTH`, 16: FIFO depth in words. Must be a power of two, ≥ 4.
- `ABITS`, `$clog2(DEPTH)`: localparam, address bits.

**Ports**
- `clock`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_tvalid_i`, in, 1: chain word valid. There is no ready; the source never stalls.
- `s_tlast_i`, in, 1: last word of a frame.
- `s_tdata_i`, in, WIDTH: chain word.
- `m_tvalid_o`, out, 1: output word valid.
- `m_tready_i`, in, 1: downstream ready.
- `m_tlast_o`, out, 1: last word of the output frame.
- `m_tdata_o`, out, WIDTH: output word.
- `overflow_o`, out, 1: one-cycle pulse when a frame is discarded.
- `level_o`, out, ABITS+1: committed words not yet read, i.e. `cmt_ptr - rd_ptr`.

## Operation

**Storage**
- Memory is DEPTH × (WIDTH+1): the stored tlast bit plus the data.

**Pointers**
- Three pointers, each ABITS+1 bits, wrapping modulo 2·DEPTH:
  - `wr_ptr`: tentative write position.
  - `cmt_ptr`: end of the last complete frame.
  - `rd_ptr`: read position.
- `full = (wr_ptr - rd_ptr) == DEPTH`. It is evaluated from the registered pointers before any same-cycle read.

**Write FSM, states ACCEPT and DROP**
- ACCEPT, `s_tvalid_i` high and not full:
  - Write the word at `wr_ptr[ABITS-1:0]`.
  - `wr_ptr++`.
  - If `s_tlast_i` is high, also set `cmt_ptr <= wr_ptr + 1`.
- ACCEPT, `s_tvalid_i` high and full:
  - Discard the word.
  - `wr_ptr <= cmt_ptr` (rewind the partial frame).
  - Pulse `overflow_o`.
  - Go to DROP, unless `s_tlast_i` is high, in which case stay in ACCEPT.
- DROP:
  - Discard all input words.
  - `s_tvalid_i && s_tlast_i` returns the FSM to ACCEPT; that word is also discarded.
  - A valid word with `s_tlast_i` low stays in DROP.
- A frame longer than DEPTH words is always discarded.

**Read side**
- `m_tvalid_o = (rd_ptr != cmt_ptr)`.
- Data and last come from an asynchronous read at `rd_ptr[ABITS-1:0]`.
- `rd_ptr++` on `m_tvalid_o && m_tready_i`.
- Uncommitted words are never visible at the output.

**Reset**
- All pointers go to 0 and the FSM to ACCEPT; `overflow_o` goes to 0.
- Memory contents are not cleared.
- Reset mid-frame discards everything, including committed data.

## Timing

**Reset values**
- `m_tvalid_o` = 0, `overflow_o` = 0, `level_o` = 0.
- `m_tdata_o` and `m_tlast_o` are don't-care while `m_tvalid_o` is 0.

**Latency**
- A frame whose tlast word is sampled at edge N produces `m_tvalid_o` = 1 after edge N.
- The first word is therefore readable in cycle N+1.

**Throughput**
- One input word per cycle and one output word per cycle, concurrently.

**Handshake**
- While `m_tvalid_o` is high and `m_tready_i` is low, `m_tdata_o` and `m_tlast_o` are held stable.
- `m_tvalid_o` does not drop without a transfer, except on reset.

**Simultaneous write and read when full**
- The write is dropped, even though the same-cycle read frees a slot.

**Overflow timing**
- `overflow_o` goes high for exactly the cycle after the edge that detected full.
- At most one pulse is produced per discarded frame.

**Wrap-around**
- Pointer arithmetic is modulo 2·DEPTH.
- `level_o` is correct across wrap.

## Configuration

- **`CHAIN_FIFO_DROP_COUNT_EN` defined:**
  - Adds output port `drop_count_o`, 16 bits, reset 0.
  - It increments on each `overflow_o` pulse and saturates at 16'hFFFF.
- **Not defined:** the port and its counter are absent; all other behaviour is identical.

## Test plan

All scenarios use WIDTH = 7 and DEPTH = 16.

1. **Basic frame:** a 5-word frame 0x01–0x05 (tlast on 0x05), with `m_tready_i` = 1.
   - `m_tvalid_o` rises the cycle after 0x05 is sampled.
   - Words 0x01–0x05 appear on consecutive cycles with `m_tlast_o` only on 0x05.
   - `level_o` peaks at 5.
2. **Backpressure:** `m_tready_i` = 0 while two 4-word frames are written.
   - `level_o` reaches 8.
   - `m_tdata_o` is held at the first word.
   - Releasing `m_tready_i` outputs 8 words in order, with tlast on words 4 and 8.
3. **Overflow mid-frame:** with `m_tready_i` = 0, a 12-word frame is followed by a 10-word frame.
   - Word 5 of the second frame hits full.
   - `overflow_o` pulses once and the remaining words are discarded.
   - After draining, only the 12-word frame appears.
   - A following 3-word frame passes intact.
4. **Oversize frame:** a 20-word frame into an empty FIFO.
   - `overflow_o` pulses on word 17.
   - `m_tvalid_o` never rises.
   - A following 2-word frame is output correctly.
5. **Wrap-around:** 40 back-to-back 3-word frames, with `m_tready_i` randomly 50 %.
   - Output data order matches input exactly.
   - `level_o` always equals the model's value.
6. **Async reset mid-frame:** reset asserted between clock edges, 2 words into a frame, with 6 committed words pending.
   - `m_tvalid_o` and `level_o` go to 0 immediately.
   - After release, a new 3-word frame is output correctly.
   - With `CHAIN_FIFO_DROP_COUNT_EN` defined, `drop_count_o` is 0.
